register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_rd_port.sv | 34 +++
 rtl/register_file.sv | 66 ++++++
 tb/tb_register_file.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing for the CPU register file and its read ports.
// Widths are derived from the register count so the address always covers the array.
package register_file_pkg;

  localparam int RF_N_REGS = 32;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADRS_W = (RF_N_REGS > 1) ? $clog2(RF_N_REGS) : 1;

  // Bench clock half-period, kept next to the sizing so both sides agree.
  localparam int RF_HCYCL = 5;

endpackage

// File: rtl/register_file_rd_port.sv
// Combinational read port: one-hot AND-OR mux over the flattened register array.
// An address with no matching register (>= N_REGS) selects nothing and reads as zero.
module register_file_rd_port
  import register_file_pkg::*;
#(
  parameter int N_REGS = RF_N_REGS,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADRS_W = RF_ADRS_W
) (
  input  logic [ADRS_W-1:0]        rd_adrs,
  input  logic [N_REGS*DATA_W-1:0] regs_flat,
  output logic [DATA_W-1:0]        q
);

  logic [N_REGS-1:0] w_hit;
  logic [DATA_W-1:0] w_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_hit
      assign w_hit[gi] = (rd_adrs == ADRS_W'(gi));
    end
  endgenerate

  always_comb begin
    w_q = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_q = w_q | ({DATA_W{w_hit[i]}} & regs_flat[i*DATA_W +: DATA_W]);
    end
  end

  assign q = w_q;

endmodule

// File: rtl/register_file.sv
// CPU general-purpose register file: two combinational read ports, one synchronous write port.
// Register 0 is ordinary storage; reset clears the whole array asynchronously.
module register_file
  import register_file_pkg::*;
#(
  parameter int N_REGS = RF_N_REGS,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADRS_W = RF_ADRS_W
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic [ADRS_W-1:0] rd_adrs_a,
  input  logic [ADRS_W-1:0] rd_adrs_b,
  input  logic [ADRS_W-1:0] wr_adrs,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0]        r_regs [N_REGS];
  logic [N_REGS*DATA_W-1:0] w_regs_flat;

  // Out-of-range write addresses match no register, so they are dropped naturally.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wr_adrs == ADRS_W'(i)) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_flat
      assign w_regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

  register_file_rd_port #(
    .N_REGS (N_REGS),
    .DATA_W (DATA_W),
    .ADRS_W (ADRS_W)
  ) u_rd_port_a (
    .rd_adrs   (rd_adrs_a),
    .regs_flat (w_regs_flat),
    .q         (q_a)
  );

  register_file_rd_port #(
    .N_REGS (N_REGS),
    .DATA_W (DATA_W),
    .ADRS_W (ADRS_W)
  ) u_rd_port_b (
    .rd_adrs   (rd_adrs_b),
    .regs_flat (w_regs_flat),
    .q         (q_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps plus a random phase,
// compared against a plain array model of the register contents.
module tb_register_file;
  import register_file_pkg::*;

  localparam int N  = RF_N_REGS;
  localparam int W  = RF_DATA_W;
  localparam int AW = RF_ADRS_W;

  logic          clk_cpu   = 1'b0;
  logic          reset     = 1'b1;
  logic [AW-1:0] rd_adrs_a = '0;
  logic [AW-1:0] rd_adrs_b = '0;
  logic [AW-1:0] wr_adrs   = '0;
  logic [W-1:0]  wr_data   = '0;
  logic          wr_en     = 1'b0;
  logic [W-1:0]  q_a;
  logic [W-1:0]  q_b;

  logic [W-1:0]  model [N];
  logic [W-1:0]  vals  [N];
  logic [W-1:0]  old_val;
  int            n_pass  = 0;
  int            n_total = 0;

  always #(RF_HCYCL) clk_cpu = ~clk_cpu;

  register_file dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .rd_adrs_a (rd_adrs_a),
    .rd_adrs_b (rd_adrs_b),
    .wr_adrs   (wr_adrs),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .q_a       (q_a),
    .q_b       (q_b)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;

    // Reset held for 5 cycles with a write attempt that must be ignored.
    wr_en = 1'b1; wr_adrs = AW'(5); wr_data = 32'h1234_5678;
    repeat (5) @(posedge clk_cpu);
    @(negedge clk_cpu);
    rd_adrs_a = AW'(5); rd_adrs_b = AW'(5);
    #1;
    check("reset_hold_a", q_a, '0);
    check("reset_hold_b", q_b, '0);
    wr_en = 1'b0;
    reset = 1'b0;
    $display("reset released at %0t", $time);

    for (int i = 0; i < N; i++) begin
      @(negedge clk_cpu);
      rd_adrs_a = AW'(i); rd_adrs_b = AW'(N-1-i);
      #1;
      check("post_reset_a", q_a, '0);
      check("post_reset_b", q_b, '0);
    end

    // Sequential fill reg[i] = i, then read back on both ports.
    for (int i = 0; i < N; i++) begin
      @(negedge clk_cpu);
      wr_en = 1'b1; wr_adrs = AW'(i); wr_data = W'(i);
      @(posedge clk_cpu);
      model[i] = W'(i);
    end
    @(negedge clk_cpu);
    wr_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_adrs_a = AW'(i); rd_adrs_b = AW'(i);
      #1;
      check("seq_a", q_a, W'(i));
      check("seq_b", q_b, W'(i));
      $display("seq read reg %0d a=%h b=%h", i, q_a, q_b);
    end

    // Parallel: write v_i to reg i while reading reg i-1 (reg 0 gets a nonzero value).
    for (int i = 0; i < N; i++) vals[i] = $urandom() | 32'h1;
    for (int i = 0; i <= N; i++) begin
      @(negedge clk_cpu);
      wr_en = (i < N); wr_adrs = AW'(i % N); wr_data = vals[i % N];
      if (i > 0) begin
        rd_adrs_a = AW'(i-1); rd_adrs_b = AW'(i-1);
        #1;
        check("par_a", q_a, vals[i-1]);
        check("par_b", q_b, vals[i-1]);
      end
      @(posedge clk_cpu);
      if (i < N) model[i] = vals[i];
    end

    // Same-address write/read: old value before the edge, new value after.
    @(negedge clk_cpu);
    old_val = model[7];
    rd_adrs_a = AW'(7); rd_adrs_b = AW'(7);
    wr_en = 1'b1; wr_adrs = AW'(7); wr_data = 32'hDEAD_BEEF;
    #1;
    check("same_before", q_a, old_val);
    @(posedge clk_cpu);
    model[7] = 32'hDEAD_BEEF;
    #1;
    check("same_after_a", q_a, 32'hDEAD_BEEF);
    check("same_after_b", q_b, 32'hDEAD_BEEF);
    @(negedge clk_cpu);
    wr_en = 1'b0; wr_data = 32'h0BAD_F00D;
    @(posedge clk_cpu);
    #1;
    check("same_wr_en0", q_a, model[7]);

    // Random phase against the model.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_cpu);
      wr_en     = 1'($urandom_range(0, 1));
      wr_adrs   = AW'($urandom_range(0, N-1));
      wr_data   = $urandom();
      rd_adrs_a = AW'($urandom_range(0, N-1));
      rd_adrs_b = AW'($urandom_range(0, N-1));
      #1;
      check("rand_a", q_a, model[rd_adrs_a]);
      check("rand_b", q_b, model[rd_adrs_b]);
      @(posedge clk_cpu);
      if (wr_en) model[wr_adrs] = wr_data;
    end

    // Async reset between edges, with a coincident write that must be dropped.
    @(negedge clk_cpu);
    wr_en = 1'b1; wr_adrs = AW'(9); wr_data = 32'hCAFE_0009;
    rd_adrs_a = AW'(9); rd_adrs_b = AW'(7);
    #1;
    check("pre_reset_b", q_b, model[7]);
    #1;
    reset = 1'b1;
    #1;
    check("async_clr_a", q_a, '0);
    check("async_clr_b", q_b, '0);
    @(posedge clk_cpu);
    #1;
    check("reset_wr_drop", q_a, '0);
    @(negedge clk_cpu);
    reset = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int i = 0; i < N; i++) begin
      rd_adrs_a = AW'(i); rd_adrs_b = AW'(i);
      #1;
      check("clr_sweep_a", q_a, model[i]);
      check("clr_sweep_b", q_b, model[i]);
    end

    // Dual-port independence.
    @(negedge clk_cpu);
    wr_en = 1'b1; wr_adrs = AW'(3); wr_data = 32'h3;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    wr_adrs = AW'(30); wr_data = 32'h1E;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    wr_en = 1'b0;
    rd_adrs_a = AW'(3); rd_adrs_b = AW'(30);
    #1;
    check("dual_a", q_a, 32'h3);
    check("dual_b", q_b, 32'h1E);
    $display("dual read a=%h b=%h", q_a, q_b);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
